// File: rtl/gf2m_pkg.sv
// Shared constants, helpers and state encoding for the digit-serial GF(2^m) multiplier.
package gf2m_pkg;

  localparam int GF_M = 233;

  // sect233 reduction polynomial without its leading x^233 term: x^74 + 1.
  localparam logic [GF_M-1:0] SECT233_TAIL = GF_M'(1) | (GF_M'(1) << 74);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_serial_mult_if.sv
// Operand/result handshake bundle between the point controller and the field multiplier.
interface gf2m_digit_serial_mult_if #(
  parameter int M = 233
) ();
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/gf2m_digit_step.sv
// One Horner step: acc*x^D + a*digit, reduced by a single fold of the D overflow bits.
module gf2m_digit_step #(
  parameter int           M         = 233,
  parameter int           D         = 8,
  parameter logic [M-1:0] POLY_TAIL = M'(1) | (M'(1) << 74)
) (
  input  logic [M-1:0] i_acc,
  input  logic [M-1:0] i_a,
  input  logic [D-1:0] i_digit,
  output logic [M-1:0] o_acc
);

  logic [M+D-1:0] w_wide;

  // NOTE: both outputs get a full default before the loops so no latch is inferred.
  always_comb begin
    w_wide = {i_acc, {D{1'b0}}};
    for (int j = 0; j < D; j++) begin
      if (i_digit[j]) w_wide = w_wide ^ ((M+D)'(i_a) << j);
    end
    // x^(M+j) == POLY_TAIL*x^j; with D <= M-K the shifted tail never leaves M bits.
    o_acc = w_wide[M-1:0];
    for (int j = 0; j < D; j++) begin
      if (w_wide[M+j]) o_acc = o_acc ^ (POLY_TAIL << j);
    end
  end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier, MSB digit first, with valid/ready on both sides.
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int           M         = GF_M,
  parameter int           D         = 8,
  parameter logic [M-1:0] POLY_TAIL = M'(SECT233_TAIL)
) (
  input logic                       clk,
  input logic                       rst,
  gf2m_digit_serial_mult_if.slave   bus
);

  localparam int N  = num_digits(M, D);
  localparam int BW = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e          r_state;
  logic [CW-1:0]   r_dcnt;
  logic [M-1:0]    r_acc;
  logic [M-1:0]    r_a;
  logic [BW-1:0]   r_b;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [M-1:0]    w_next_acc;
  logic            w_accept;

  assign w_accept = bus.in_valid && r_in_ready;

  // b is held MSB-aligned so the active digit is always the top D bits.
  gf2m_digit_step #(
    .M         (M),
    .D         (D),
    .POLY_TAIL (POLY_TAIL)
  ) u_step (
    .i_acc   (r_acc),
    .i_a     (r_a),
    .i_digit (r_b[BW-1 -: D]),
    .o_acc   (w_next_acc)
  );

  // NOTE: operand registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_a <= bus.a;
      r_b <= BW'(bus.b);
    end else if (r_state == ST_BUSY) begin
      r_b <= r_b << D;
    end
  end

  // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_dcnt      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc      <= '0;
            r_dcnt     <= CW'(N - 1);
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_acc  <= w_next_acc;
          r_dcnt <= r_dcnt - 1'b1;
          if (r_dcnt == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_acc;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Scoreboard bench: four multipliers (D = 1, 8, 32, 159) checked against a long-division model.
module tb_gf2m_digit_serial_mult;
  import gf2m_pkg::*;

  localparam int M  = GF_M;
  localparam int NI = 4;
  localparam int DS [NI] = '{1, 8, 32, 159};
  localparam int MAIN = 1;

  logic clk;
  logic rst;

  logic         tv_in_valid  [NI];
  logic [M-1:0] tv_a         [NI];
  logic [M-1:0] tv_b         [NI];
  logic         tv_out_ready [NI];
  wire          tv_in_ready  [NI];
  wire          tv_out_valid [NI];
  wire  [M-1:0] tv_c         [NI];

  int n_pass;
  int n_total;
  logic [M-1:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gf2m_digit_serial_mult_if #(.M(M)) ifc ();
    assign ifc.in_valid  = tv_in_valid[g];
    assign ifc.a         = tv_a[g];
    assign ifc.b         = tv_b[g];
    assign ifc.out_ready = tv_out_ready[g];
    assign tv_in_ready[g]  = ifc.in_ready;
    assign tv_out_valid[g] = ifc.out_valid;
    assign tv_c[g]         = ifc.c;

    gf2m_digit_serial_mult #(
      .M         (M),
      .D         (DS[g]),
      .POLY_TAIL (SECT233_TAIL)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
  end

  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] f;
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ ((2*M)'(a) << i);
    end
    f = (2*M)'(SECT233_TAIL) | ((2*M)'(1) << M);
    for (int i = 2*M-2; i >= M; i--) begin
      if (p[i]) p = p ^ (f << (i - M));
    end
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_el();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    return w[M-1:0];
  endfunction

  function automatic logic [M-1:0] mono(input int k);
    logic [M-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // One full transaction: wait ready, accept, check latency/ready/result, optional back-pressure.
  task automatic do_op(input int idx, input logic [M-1:0] a, input logic [M-1:0] b,
                       input logic [M-1:0] exp, input string name, input int hold);
    int           cyc;
    int           n_exp;
    logic         busy_ok;
    logic         hold_ok;
    logic [M-1:0] want;
    n_exp = num_digits(M, DS[idx]);
    cyc = 0;
    while (tv_in_ready[idx] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (tv_in_ready[idx] !== 1'b1) begin
      $display("FAIL %s d%0d ready_wait: in_ready=%b required 1", name, DS[idx], tv_in_ready[idx]);
      return;
    end
    n_pass++;
    tv_in_valid[idx] = 1'b1;
    tv_a[idx] = a;
    tv_b[idx] = b;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    tv_in_valid[idx] = 1'b0;
    tv_a[idx] = '0;
    tv_b[idx] = '0;
    busy_ok = 1'b1;
    cyc = 0;
    while (tv_out_valid[idx] !== 1'b1 && cyc < 400) begin
      if (tv_in_ready[idx] !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (tv_in_ready[idx] !== 1'b0) busy_ok = 1'b0;
    n_total++;
    if (cyc != n_exp)
      $display("FAIL %s d%0d latency: got %0d cycles required %0d", name, DS[idx], cyc, n_exp);
    else n_pass++;
    n_total++;
    if (!busy_ok)
      $display("FAIL %s d%0d in_ready_busy: in_ready seen 1 required 0 during BUSY/DONE", name, DS[idx]);
    else n_pass++;
    want = sb_q.pop_front();
    n_total++;
    if (tv_c[idx] !== want)
      $display("FAIL %s d%0d result: got %h required %h", name, DS[idx], tv_c[idx], want);
    else n_pass++;
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (tv_c[idx] !== want || tv_out_valid[idx] !== 1'b1 || tv_in_ready[idx] !== 1'b0)
          hold_ok = 1'b0;
      end
      n_total++;
      if (!hold_ok)
        $display("FAIL %s d%0d hold: c=%h out_valid=%b in_ready=%b required c=%h 1 0",
                 name, DS[idx], tv_c[idx], tv_out_valid[idx], tv_in_ready[idx], want);
      else n_pass++;
    end
    tv_out_ready[idx] = 1'b1;
    @(negedge clk);
    tv_out_ready[idx] = 1'b0;
    n_total++;
    if (tv_out_valid[idx] !== 1'b0 || tv_in_ready[idx] !== 1'b1)
      $display("FAIL %s d%0d release: out_valid=%b in_ready=%b required 0 1",
               name, DS[idx], tv_out_valid[idx], tv_in_ready[idx]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if (tv_in_ready[i] !== 1'b0 || tv_out_valid[i] !== 1'b0 || tv_c[i] !== '0)
        $display("FAIL reset_hold d%0d: in_ready=%b out_valid=%b c=%h required 0 0 0",
                 DS[i], tv_in_ready[i], tv_out_valid[i], tv_c[i]);
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if (tv_in_ready[i] !== 1'b1)
        $display("FAIL reset_release d%0d: in_ready=%b required 1", DS[i], tv_in_ready[i]);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    do_op(MAIN, M'(1), M'(1), M'(1), "one_x_one", 0);
    do_op(MAIN, mono(232), mono(1), mono(74) | mono(0), "x232_x1", 0);
    do_op(MAIN, mono(232), mono(232), mono(231) | mono(146) | mono(72), "x232_x232", 0);
  endtask

  task automatic test_random();
    logic [M-1:0] a;
    logic [M-1:0] b;
    int           ops;
    for (int i = 0; i < NI; i++) begin
      do_op(i, '0, rand_el(), '0, "zero", 0);
      do_op(i, {M{1'b1}}, {M{1'b1}}, ref_mul({M{1'b1}}, {M{1'b1}}), "all_ones", 0);
      ops = (DS[i] == 1) ? 25 : 150;
      for (int k = 0; k < ops; k++) begin
        a = rand_el();
        b = rand_el();
        do_op(i, a, b, ref_mul(a, b), "random", 0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [M-1:0] a;
    logic [M-1:0] b;
    a = rand_el();
    b = rand_el();
    do_op(MAIN, a, b, ref_mul(a, b), "backpressure", 50);
  endtask

  task automatic test_reset_midbusy();
    logic seen;
    @(negedge clk);
    n_total++;
    if (tv_in_ready[MAIN] !== 1'b1)
      $display("FAIL midbusy_ready: in_ready=%b required 1", tv_in_ready[MAIN]);
    else n_pass++;
    tv_in_valid[MAIN] = 1'b1;
    tv_a[MAIN] = rand_el() | M'(1);
    tv_b[MAIN] = rand_el() | mono(M-1);
    @(posedge clk);
    @(negedge clk);
    tv_in_valid[MAIN] = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (tv_out_valid[MAIN] !== 1'b0 || tv_c[MAIN] !== '0 || tv_in_ready[MAIN] !== 1'b0)
      $display("FAIL midbusy_in_reset: out_valid=%b c=%h in_ready=%b required 0 0 0",
               tv_out_valid[MAIN], tv_c[MAIN], tv_in_ready[MAIN]);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (tv_in_ready[MAIN] !== 1'b1 || tv_c[MAIN] !== '0)
      $display("FAIL midbusy_after: in_ready=%b c=%h required 1 0", tv_in_ready[MAIN], tv_c[MAIN]);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tv_out_valid[MAIN] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen) $display("FAIL midbusy_no_output: out_valid seen 1 required 0");
    else n_pass++;
    do_op(MAIN, M'(3), M'(5), M'(15), "after_abort", 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    for (int i = 0; i < NI; i++) begin
      tv_in_valid[i]  = 1'b0;
      tv_a[i]         = '0;
      tv_b[i]         = '0;
      tv_out_ready[i] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midbusy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
